// File: rtl/cfir_pkg.sv
// Shared constants, FSM state type and output rounding/saturation for the complex-FIR MAC engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: CFIR_DW/CFIR_TAPS/CFIR_ACC_W/CFIR_FRAC, cfir_state_t, sat16().
package cfir_pkg;

  localparam int CFIR_DW    = 16;
  localparam int CFIR_TAPS  = 32;
  localparam int CFIR_ACC_W = 40;
  localparam int CFIR_FRAC  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } cfir_state_t;

  localparam logic signed [CFIR_ACC_W-1:0] CFIR_SAT_MAX = CFIR_ACC_W'((1 << (CFIR_DW-1)) - 1);
  localparam logic signed [CFIR_ACC_W-1:0] CFIR_SAT_MIN = -(CFIR_SAT_MAX + CFIR_ACC_W'(1));

  // Round half-up (add half an output LSB, then arithmetic shift) and clamp
  // to the signed output range.
  function automatic logic [CFIR_DW-1:0] sat16(input logic signed [CFIR_ACC_W-1:0] acc,
                                               input int frac);
    logic signed [CFIR_ACC_W-1:0] half;
    logic signed [CFIR_ACC_W-1:0] rnd;
    logic signed [CFIR_ACC_W-1:0] shf;
    half = CFIR_ACC_W'(1) << (frac - 1);
    rnd  = acc + half;
    shf  = rnd >>> frac;
    if (shf > CFIR_SAT_MAX) begin
      sat16 = {1'b0, {(CFIR_DW-1){1'b1}}};
    end else if (shf < CFIR_SAT_MIN) begin
      sat16 = {1'b1, {(CFIR_DW-1){1'b0}}};
    end else begin
      sat16 = shf[CFIR_DW-1:0];
    end
  endfunction

endpackage

// File: rtl/cfir_mac_unit.sv
// Single-multiplier MAC datapath: optional symmetric pre-add, signed multiply, accumulate.
// Latency: product enters the accumulator at the same edge (no internal pipeline).
// Backpressure: none; the owner drives en/clr every cycle.
// Ports: CLK, rst (sync, active-high), clr (sync clear), en (accumulate), a/b (taps), coef, acc.
// Build option: CFIR_SYMMETRIC_EN adds the pre-adder a+b (17-bit) ahead of a 33-bit product.
module cfir_mac_unit
  import cfir_pkg::*;
#(
  parameter int DW    = CFIR_DW,
  parameter int ACC_W = CFIR_ACC_W
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic signed [DW-1:0]    coef,
  output logic signed [ACC_W-1:0] acc
);

`ifdef CFIR_SYMMETRIC_EN
  localparam int PW = 2*DW + 1;

  // Pre-add is one bit wider so snap[k] + snap[31-k] never wraps.
  logic signed [DW:0]   pre;
  logic signed [PW-1:0] pre_x;
  logic signed [PW-1:0] coef_x;
  logic signed [PW-1:0] prod;

  assign pre    = {a[DW-1], a} + {b[DW-1], b};
  assign pre_x  = {{(PW-DW-1){pre[DW]}}, pre};
  assign coef_x = {{(PW-DW){coef[DW-1]}}, coef};
  assign prod   = pre_x * coef_x;
`else
  localparam int PW = 2*DW;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] coef_x;
  logic signed [PW-1:0] prod;
  logic                 unused_b;

  assign a_x      = {{(PW-DW){a[DW-1]}}, a};
  assign coef_x   = {{(PW-DW){coef[DW-1]}}, coef};
  assign prod     = a_x * coef_x;
  assign unused_b = ^b;
`endif

  logic signed [ACC_W-1:0] prod_ext;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/cfir_serial_mac.sv
// Time-multiplexed 32-tap complex-FIR MAC: snapshot taps on start, serial MAC, round/saturate to 16 bits.
// Latency: out_valid one cycle after edge k+33 (k+17 with CFIR_SYMMETRIC_EN) for start sampled at edge k.
// Backpressure: none; start while busy (including the DONE cycle) is dropped and sets sticky overrun.
// Ports: CLK, rst (sync, active-high), start, taps (Q(i+1) at [16i+15:16i]), coef_we/coef_addr/coef_data,
//        dout, out_valid (1-cycle pulse), busy, overrun (sticky until rst).
// Build option: CFIR_SYMMETRIC_EN selects the 16-cycle linear-phase variant (coef[16..31] unused).
module cfir_serial_mac
  import cfir_pkg::*;
#(
  parameter int DW    = CFIR_DW,
  parameter int TAPS  = CFIR_TAPS,
  parameter int ACC_W = CFIR_ACC_W,
  parameter int FRAC  = CFIR_FRAC
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TAPS*DW-1:0]   taps,
  input  logic                 coef_we,
  input  logic [4:0]           coef_addr,
  input  logic [DW-1:0]        coef_data,
  output logic [DW-1:0]        dout,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(TAPS);

`ifdef CFIR_SYMMETRIC_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS/2 - 1);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);
`endif

  cfir_state_t state_q;
  cfir_state_t state_d;

  logic [CNT_W-1:0]        cnt;
  logic signed [DW-1:0]    snap   [TAPS];
  logic signed [DW-1:0]    coef_q [TAPS];
  logic signed [ACC_W-1:0] acc;

  logic snap_ld;
  logic acc_clr;
  logic acc_en;
  logic done;

  assign busy = (state_q != IDLE);

  // Next-state and per-cycle controls.
  always_comb begin
    state_d = state_q;
    snap_ld = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_ld = 1'b1;
          acc_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_en = 1'b1;
        if (cnt == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      out_valid <= done;
      if (done) begin
        dout <= sat16(acc, FRAC);
      end
      if (start && busy) begin
        overrun <= 1'b1;
      end
      if (snap_ld) begin
        cnt <= '0;
      end else if (acc_en) begin
        cnt <= cnt + 1'b1;
      end
      // Writes in IDLE land at the same edge as a start, so the new run
      // already sees the updated coefficient.
      if (coef_we && !busy) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  // Snapshot is data-only; its contents are irrelevant until a start loads it.
  always_ff @(posedge CLK) begin
    if (snap_ld) begin
      for (int i = 0; i < TAPS; i++) begin
        snap[i] <= taps[i*DW +: DW];
      end
    end
  end

  logic signed [DW-1:0] mac_a;
  logic signed [DW-1:0] mac_b;
  logic signed [DW-1:0] mac_c;

  // ~cnt is 31-cnt for a 5-bit counter: the mirror tap for the pre-add.
  assign mac_a = snap[cnt];
  assign mac_b = snap[~cnt];
  assign mac_c = coef_q[cnt];

  cfir_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .CLK  (CLK),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .a    (mac_a),
    .b    (mac_b),
    .coef (mac_c),
    .acc  (acc)
  );

endmodule

// File: tb/tb_cfir_serial_mac.sv
// Directed bench for cfir_serial_mac with an expected-result queue popped on out_valid.
// Latency: checks out_valid lands exactly LAT edges after the accepted start.
// Backpressure: exercises dropped starts (busy and DONE cycle) and ignored coefficient writes.
module tb_cfir_serial_mac;

  localparam int DW   = 16;
  localparam int TAPS = 32;
`ifdef CFIR_SYMMETRIC_EN
  localparam int LAT = 17;
  localparam bit SYM = 1'b1;
`else
  localparam int LAT = 33;
  localparam bit SYM = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [TAPS*DW-1:0] taps = '0;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = '0;
  logic [DW-1:0]      coef_data = '0;
  logic [DW-1:0]      dout;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  cfir_serial_mac dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .taps      (taps),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .dout      (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_vld_cyc = -1;
  int kcyc = 0;
  int p0 = 0;

  logic [DW-1:0]        exp_q [$];
  logic signed [DW-1:0] mcoef [TAPS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Any out_valid pops the scoreboard.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge CLK);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      pulses++;
      last_vld_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out_valid observed=%h expected=none", dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) mcoef[i] = '0;
  endtask

  task automatic write_coef(input int a, input logic [DW-1:0] d);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = d;
    tick();
    coef_we   = 1'b0;
    mcoef[a]  = d;
  endtask

  task automatic set_tap(input int i, input logic [DW-1:0] v);
    taps[i*DW +: DW] = v;
  endtask

  task automatic launch(input logic [DW-1:0] e);
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    kcyc = cyc;
  endtask

  task automatic await_out(input string tag);
    int n;
    int q0;
    n  = 0;
    q0 = pulses;
    while (pulses == q0 && n < LAT + 10) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, (pulses != q0) ? 32'(last_vld_cyc - kcyc) : 32'hffff_ffff, 32'(LAT));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  // Reference: direct sum of products, round half-up, saturate.
  function automatic logic [DW-1:0] model();
    longint acc;
    longint r;
    logic signed [DW-1:0] ti;
    logic signed [DW-1:0] tj;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      ti = taps[k*DW +: DW];
      tj = taps[(TAPS-1-k)*DW +: DW];
      if (!SYM) acc += longint'(ti) * longint'(mcoef[k]);
      else if (k < TAPS/2) acc += (longint'(ti) + longint'(tj)) * longint'(mcoef[k]);
    end
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) return 16'h7fff;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;

    // Reset state
    do_reset();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Impulse
    write_coef(0, 16'h4000);
    taps = '0;
    set_tap(0, 16'h2000);
    launch(16'h1000);
    chk("busy_after_start", 32'(busy), 32'd1);
    await_out("impulse");
    tick();
    chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("dout_hold", 32'(dout), 32'h1000);

    // Rounding, issued back-to-back (start in the IDLE cycle right after DONE)
    write_coef(0, 16'h0001);
    set_tap(0, 16'h4000);
    launch(16'h0001);
    await_out("round_up");
    set_tap(0, 16'h3fff);
    launch(16'h0000);
    await_out("round_down");
    set_tap(0, 16'hc000);
    launch(16'h0000);
    await_out("round_neg_half");
    set_tap(0, 16'hbfff);
    launch(16'hffff);
    await_out("round_neg");
    chk("no_overrun_back_to_back", 32'(overrun), 32'd0);

    // Saturation
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'h7fff);
    for (int i = 0; i < TAPS; i++) set_tap(i, 16'h7fff);
    launch(16'h7fff);
    await_out("sat_pos");
    for (int i = 0; i < TAPS; i++) set_tap(i, 16'h8000);
    launch(16'h8000);
    await_out("sat_neg");

    // Random coefficients and taps against the reference sum
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < TAPS; i++) begin
        r = $urandom;
        write_coef(i, {{4{r[11]}}, r[11:0]});
      end
      for (int i = 0; i < TAPS; i++) set_tap(i, 16'($urandom));
      launch(model());
      await_out("random");
    end

    // Coefficient write in the same cycle as start is used by that run
    do_reset();
    taps = '0;
    set_tap(0, 16'h2000);
    coef_we   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 16'h2000;
    mcoef[0]  = 16'h2000;
    launch(16'h0800);
    coef_we = 1'b0;
    await_out("write_with_start");

    // Overrun: second start at k+10 dropped, coef write at k+5 ignored
    write_coef(0, 16'h4000);
    launch(16'h1000);
    p0 = pulses;
    for (int n = 1; n <= LAT + 6; n++) begin
      coef_we   = (n == 5);
      coef_addr = 5'd0;
      coef_data = 16'h7fff;
      start     = (n == 10);
      tick();
    end
    coef_we = 1'b0;
    start   = 1'b0;
    chk("overrun_one_pulse", 32'(pulses - p0), 32'd1);
    chk("overrun_latency", 32'(last_vld_cyc - kcyc), 32'(LAT));
    chk("overrun_set", 32'(overrun), 32'd1);
    launch(16'h1000);
    await_out("coef_unchanged");
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a run
    launch(16'h1000);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) mcoef[i] = '0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    p0 = pulses;
    repeat (40) tick();
    chk("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    for (int i = 0; i < TAPS; i++) set_tap(i, 16'h7fff);
    launch(16'h0000);
    await_out("coef_cleared");

    // Start during the DONE cycle is dropped
    write_coef(0, 16'h4000);
    taps = '0;
    set_tap(0, 16'h2000);
    launch(16'h1000);
    p0 = pulses;
    for (int n = 1; n <= LAT + 6; n++) begin
      start = (n == LAT);
      tick();
    end
    start = 1'b0;
    chk("done_start_one_pulse", 32'(pulses - p0), 32'd1);
    chk("done_start_overrun", 32'(overrun), 32'd1);
    chk("done_start_idle", 32'(busy), 32'd0);

    // Mirror tap pair Q1/Q32 with coef[0]
    taps = '0;
    set_tap(0, 16'h1000);
    set_tap(TAPS-1, 16'h1000);
    launch(SYM ? 16'h1000 : 16'h0800);
    await_out("mirror_pair");

    // coef[31] drives Q32 in the full build and is unused in the symmetric build
    write_coef(0, 16'h0000);
    write_coef(31, 16'h4000);
    taps = '0;
    set_tap(TAPS-1, 16'h2000);
    launch(SYM ? 16'h0000 : 16'h1000);
    await_out("coef31_q32");

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
